// File: rtl/fifo_uart_tx.sv
// 8N1 serial transmitter that drains a synchronous FIFO one byte per frame.
// All outputs are registered. Reset is synchronous and active-high.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntDone = CntW'(CLKS_PER_BIT - 2);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StStart,
        StData,
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              rd_en_q, rd_en_d;
    logic              done_q, done_d;

    logic              fetch_ok;
    logic              bit_end;
    logic [DATA_W-1:0] shift_nxt;

    assign fetch_ok  = enable && !fifo_empty;
    assign bit_end   = (cnt_q == CntLast);
    assign shift_nxt = shift_q >> 1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        rd_en_d = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (fetch_ok) begin
                    state_d = StFetch;
                    rd_en_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            StFetch: begin
                state_d = StLatch;
                busy_d  = 1'b1;
            end
            StLatch: begin
                shift_d = fifo_data;
                cnt_d   = '0;
                state_d = StStart;
                tx_d    = 1'b0;
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = StData;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_nxt;
                    idx_d   = idx_q + IdxW'(1);
                    if (idx_q == IdxLast) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d = shift_nxt[0];
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                // Registered pulse: raise it one edge early so it lands in the last stop cycle.
                if (cnt_q == CntDone) begin
                    done_d = 1'b1;
                end
                if (bit_end) begin
                    cnt_d = '0;
                    if (fetch_ok) begin
                        state_d = StFetch;
                        rd_en_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            rd_en_q <= rd_en_d;
            done_q  <= done_d;
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO stand-in, frame-position reference model checked every
// cycle, serial receiver, and directed scenarios with hand-computed expectations.
module tb_fifo_uart_tx;

    localparam int CPB   = 4;
    localparam int DW    = 8;
    localparam int FRAME = (DW + 2) * CPB + 2;  // fetch + latch + start/data/stop

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd_en;
    logic          tx;
    logic          busy;
    logic          tx_done;

    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            rd_cnt = 0;
    int            done_cnt = 0;
    int            busy_cnt = 0;
    int            last_rd_cyc = 0;
    logic [7:0]    fifo_q[$];
    logic [7:0]    rx_q[$];
    int            low_runs[$];
    int            done_cyc_q[$];

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: t is the cycle position within a fetch+frame, -1 when idle.
    initial begin
        int         t;
        int         k;
        int         j;
        int         rx_cnt;
        int         cur_low;
        logic [7:0] eb;
        logic [7:0] rx_sh;
        logic       etx;
        t       = -1;
        rx_cnt  = -1;
        cur_low = 0;
        eb      = 8'h00;
        rx_sh   = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (t < 0) begin
                etx = 1'b1;
            end else if (t < 2) begin
                etx = 1'b1;
            end else begin
                k = (t - 2) / CPB;
                if (k == 0) etx = 1'b0;
                else if (k > DW) etx = 1'b1;
                else etx = eb[k-1];
            end
            check("tx", tx, etx);
            check("busy", busy, (t >= 0));
            check("rd_en", fifo_rd_en, (t == 0));
            check("tx_done", tx_done, (t == FRAME - 1));

            if (fifo_rd_en) begin
                rd_cnt++;
                last_rd_cyc = cyc;
            end
            if (tx_done) begin
                done_cnt++;
                done_cyc_q.push_back(cyc);
            end
            if (busy) busy_cnt++;
            if (tx == 1'b0) begin
                cur_low++;
            end else if (cur_low > 0) begin
                low_runs.push_back(cur_low);
                cur_low = 0;
            end

            // Mid-bit sampling receiver
            if (reset) begin
                rx_cnt = -1;
            end else if (rx_cnt < 0) begin
                if (tx == 1'b0) rx_cnt = 1;
            end else begin
                if (rx_cnt % CPB == CPB / 2) begin
                    j = rx_cnt / CPB;
                    if (j >= 1 && j <= DW) begin
                        rx_sh[j-1] = tx;
                    end else if (j == DW + 1) begin
                        rx_q.push_back(rx_sh);
                        rx_cnt = -2;
                    end
                end
                rx_cnt++;
            end

            // FIFO stand-in: pop then push, data presented from the FETCH cycle on
            if (fifo_rd_en) begin
                if (fifo_q.size() == 0) check("underflow_read", 1, 0);
                else fifo_data = fifo_q.pop_front();
            end
            if (wr_en) fifo_q.push_back(wr_data);
            fifo_empty = (fifo_q.size() == 0);

            if (reset) begin
                t = -1;
            end else if (t < 0 || t == FRAME - 1) begin
                if (enable && !fifo_empty) begin
                    t  = 0;
                    eb = fifo_q[0];
                end else begin
                    t = -1;
                end
            end else begin
                t++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        @(posedge clk);
        #1;
        wr_data = b;
        wr_en   = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    initial begin
        int         r0;
        int         d0;
        int         b0;
        int         x0;
        int         l0;
        int         c0;
        logic [7:0] burst[8];
        burst = '{8'h01, 8'h80, 8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'h7E, 8'hE7};

        // 1: reset held with empty FIFO
        step(3);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_done", tx_done, 0);
        reset = 1'b0;
        step(6);
        check("idle_rd_cnt", rd_cnt, 0);
        check("idle_tx", tx, 1);

        // 2: single byte 0x24
        r0 = rd_cnt; d0 = done_cnt; b0 = busy_cnt; x0 = rx_q.size(); l0 = low_runs.size();
        push(8'h24);
        step(FRAME + 8);
        check("b24_rd", rd_cnt - r0, 1);
        check("b24_done", done_cnt - d0, 1);
        check("b24_busy_len", busy_cnt - b0, 42);
        check("b24_rx_n", rx_q.size() - x0, 1);
        check("b24_rx", rx_q[x0], 8'h24);
        check("b24_nlow", low_runs.size() - l0, 3);
        check("b24_low0", low_runs[l0], 12);
        check("b24_low1", low_runs[l0+1], 8);
        check("b24_low2", low_runs[l0+2], 8);
        check("b24_done_pos", done_cyc_q[done_cyc_q.size()-1] - last_rd_cyc, 41);

        // 3: eight queued bytes, then enable
        enable = 1'b0;
        r0 = rd_cnt; d0 = done_cnt; x0 = rx_q.size(); c0 = done_cyc_q.size();
        for (int i = 0; i < 8; i++) push(burst[i]);
        check("burst_count", fifo_q.size(), 8);
        enable = 1'b1;
        step(8 * FRAME + 10);
        check("burst_rd", rd_cnt - r0, 8);
        check("burst_done", done_cnt - d0, 8);
        check("burst_rx_n", rx_q.size() - x0, 8);
        for (int i = 0; i < 8; i++) check("burst_rx", rx_q[x0+i], burst[i]);
        for (int i = 1; i < 8; i++) check("burst_gap", done_cyc_q[c0+i] - done_cyc_q[c0+i-1], 42);
        check("burst_fifo_empty", fifo_q.size(), 0);
        check("burst_busy_end", busy, 0);

        // 4: drop enable during data bit 3 of the first of two bytes
        enable = 1'b0;
        r0 = rd_cnt; d0 = done_cnt; x0 = rx_q.size();
        push(8'h3A);
        push(8'hC5);
        enable = 1'b1;
        step(19);
        enable = 1'b0;
        step(60);
        check("en_rd", rd_cnt - r0, 1);
        check("en_done", done_cnt - d0, 1);
        check("en_left", fifo_q.size(), 1);
        check("en_busy", busy, 0);
        check("en_rx0", rx_q[x0], 8'h3A);
        enable = 1'b1;
        step(FRAME + 8);
        check("en_rd2", rd_cnt - r0, 2);
        check("en_done2", done_cnt - d0, 2);
        check("en_rx1", rx_q[x0+1], 8'hC5);

        // 5: reset during data bit 5 of 0xA5
        enable = 1'b0;
        r0 = rd_cnt; d0 = done_cnt; x0 = rx_q.size();
        push(8'hA5);
        enable = 1'b1;
        step(27);
        reset = 1'b1;
        step(1);
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", tx_done, 0);
        reset = 1'b0;
        step(40);
        check("mid_rst_rd", rd_cnt - r0, 1);
        check("mid_rst_ndone", done_cnt - d0, 0);
        check("mid_rst_rx", rx_q.size() - x0, 0);
        check("mid_rst_idle", busy, 0);

        // 6: 0x00 then 0xFF back to back
        enable = 1'b0;
        x0 = rx_q.size(); l0 = low_runs.size();
        push(8'h00);
        push(8'hFF);
        enable = 1'b1;
        step(2 * FRAME + 10);
        check("ext_nlow", low_runs.size() - l0, 2);
        check("ext_low00", low_runs[l0], 36);
        check("ext_lowff", low_runs[l0+1], 4);
        check("ext_rx0", rx_q[x0], 8'h00);
        check("ext_rx1", rx_q[x0+1], 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream consumer of sync_fifo. It pops bytes from the FIFO whenever the FIFO is non-empty and transmission is enabled. Each byte is sent as a standard 8N1 serial frame: start bit, 8 data bits LSB first, one stop bit. It drives the FIFO's rd_en and consumes its registered data_out and empty flags. The tx line feeds the board-level serial pin.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range ≥2.
DATA_W, 8, data width; must match the FIFO width; the frame carries exactly DATA_W data bits.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  permits new FIFO fetches; does not abort an in-flight frame
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_W  FIFO data_out; valid the cycle after rd_en is sampled
fifo_rd_en  output  1  FIFO read strobe; registered; exactly one cycle per byte
tx  output  1  serial line; idle high; registered
busy  output  1  high from FETCH through the last STOP cycle
tx_done  output  1  one-cycle pulse in the final cycle of each stop bit

Behaviour:
- One clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, tx=1, busy=0, fifo_rd_en=0, tx_done=0. Baud counter and bit index are 0. Shift register is 0.
- States: IDLE, FETCH, LATCH, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - If enable=1 and fifo_empty=0, go to FETCH.
- FETCH (1 cycle):
  - fifo_rd_en=1, busy=1.
  - Always go to LATCH.
- LATCH (1 cycle):
  - fifo_rd_en=0.
  - Shift register ← fifo_data; go to START with baud counter=0.
- START:
  - tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
- DATA:
  - tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right and increment the bit index.
  - After bit DATA_W-1, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles; tx_done=1 in the last of these cycles.
  - At that cycle's edge: if enable=1 and fifo_empty=0, go to FETCH (back-to-back); else go to IDLE.
- Latency: fetch decision to tx falling edge = 2 cycles (FETCH, LATCH). Frame length = (DATA_W+2)*CLKS_PER_BIT cycles.
- Back-to-back gap: exactly 2 tx-high cycles between a stop bit and the next start bit.
- Counter widths:
  - Baud counter is $clog2(CLKS_PER_BIT) bits and wraps to 0 at CLKS_PER_BIT-1.
  - Bit index is $clog2(DATA_W) bits.
- fifo_empty and enable are sampled only in IDLE and in the last STOP cycle. They are ignored elsewhere.
- fifo_rd_en is never asserted while fifo_empty=1 at the decision edge. Therefore no underflow read is issued.
- enable dropping mid-frame: the current frame completes, tx_done pulses, and the block goes to IDLE. No further rd_en is issued while enable=0.
- Reset mid-frame:
  - Next edge: tx=1, busy=0, and state=IDLE; no tx_done.
  - The popped byte is discarded.
  - Reset in FETCH does not extend rd_en; rd_en=0 on the next cycle.
- fifo_data is sampled only in LATCH. Later FIFO changes do not affect the frame.

Test Plan:
1. Reset held 3 cycles, fifo_empty=1, enable=1 → tx=1, busy=0, fifo_rd_en=0, tx_done=0 throughout and after release.
2. CLKS_PER_BIT=4; FIFO holds 0x24; enable=1 → checks:
   - One rd_en pulse.
   - tx low 4 cycles, then bits 0,0,1,0,0,1,0,0 for 4 cycles each, then high 4 cycles.
   - One tx_done in the 40th frame cycle; busy high 42 cycles.
3. Write 8 bytes (FIFO full, count=8) then enable → checks:
   - 8 rd_en pulses and 8 frames, each separated by exactly 2 high cycles.
   - Bytes appear in write order; FIFO ends empty with count=0; busy falls after the 8th tx_done.
4. Two bytes queued; drop enable during frame 1 data bit 3 → frame 1 completes with tx_done, then IDLE. No rd_en until enable returns; then frame 2 is sent.
5. Assert reset during data bit 5 of byte 0xA5 → next edge tx=1, busy=0; no tx_done. After release with FIFO empty, no activity.
6. Bytes 0x00 and 0xFF back-to-back → checks:
   - 0x00 frame: tx low for 36 contiguous cycles (start+data), then high.
   - 0xFF frame: tx low only during its 4-cycle start bit.
